// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: bit-serial add/subtract sequencer.
// One 1-bit full-adder slice (two half adders plus OR) is reused across
// WIDTH cycles. Operands are captured on start, shifted LSB first through
// the slice, and the result is presented together with a one-cycle done.
// Optional feature macro: SERIAL_ADDSUB_OVF_EN adds the signed-overflow
// output ovf and its flop; when undefined neither exists.
module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic             carry
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Half adder: returns {carry, sum}.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    half_add = {x & y, x ^ y};
  endfunction

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res_sr;
  logic             r_cy;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_y;
  logic             r_carry;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             r_ovf;
`endif

  logic [1:0]       w_ha1;
  logic [1:0]       w_ha2;
  logic             w_sum;
  logic             w_cy_next;
  logic [WIDTH-1:0] w_res_next;
  logic             w_accept;
  logic             w_last;

  // Full-adder slice on the current LSBs and the running carry.
  always_comb begin
    w_ha1      = half_add(r_a_sr[0], r_b_sr[0]);
    w_ha2      = half_add(w_ha1[0], r_cy);
    w_sum      = w_ha2[0];
    w_cy_next  = w_ha1[1] | w_ha2[1];
    w_res_next = {w_sum, r_res_sr[WIDTH-1:1]};
    w_accept   = (r_state == IDLE) && start;
    w_last     = (r_state == RUN) && (r_cnt == CW'(WIDTH - 1));
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state: IDLE -> RUN on start, RUN -> DONE on last bit, DONE -> IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = RUN;
        end else begin
          w_state_next = IDLE;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_next = DONE;
        end else begin
          w_state_next = RUN;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Operand capture, serial shift/accumulate and result latching.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr   <= {WIDTH{1'b0}};
      r_b_sr   <= {WIDTH{1'b0}};
      r_res_sr <= {WIDTH{1'b0}};
      r_cy     <= 1'b0;
      r_cnt    <= {CW{1'b0}};
      r_y      <= {WIDTH{1'b0}};
      r_carry  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else if (w_accept) begin
      // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
      r_a_sr <= A;
      r_b_sr <= sub ? ~B : B;
      r_cy   <= sub;
      r_cnt  <= {CW{1'b0}};
    end else if (r_state == RUN) begin
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_cy     <= w_cy_next;
      r_res_sr <= w_res_next;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) begin
        r_y     <= w_res_next;
        r_carry <= w_cy_next;
`ifdef SERIAL_ADDSUB_OVF_EN
        // Carry into the MSB differs from carry out of it on signed overflow.
        r_ovf   <= r_cy ^ w_cy_next;
`endif
      end
    end
  end

  assign ready = (r_state == IDLE);
  assign busy  = (r_state == RUN);
  assign done  = (r_state == DONE);
  assign Y     = r_y;
  assign carry = r_carry;
`ifdef SERIAL_ADDSUB_OVF_EN
  assign ovf   = r_ovf;
`endif

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed testbench for serial_addsub_ctrl (WIDTH=8).
module tb_serial_addsub_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Y;
  logic             carry;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf;
`endif

  int n_total;
  int n_bad;

  serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .A     (A),
    .B     (B),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .Y     (Y),
    .carry (carry)
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done; lat counts the accept edge as 1.
  task automatic wait_done(output int lat);
    bit found;
    found = 1'b0;
    lat = 1;
    while (!found && lat < 40) begin
      tick();
      lat++;
      if (done) found = 1'b1;
    end
    if (!found) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [7:0] ey, input logic ec,
                        input logic eo);
    int lat;
    A = a; B = b; sub = s; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(lat);
    chk({tag, "_lat"}, 32'(lat), 32'd9);
    chk({tag, "_y"}, 32'(Y), 32'(ey));
    chk({tag, "_carry"}, 32'(carry), 32'(ec));
`ifdef SERIAL_ADDSUB_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) chk({tag, "_eo"}, 32'd0, 32'd1);
`endif
    tick();
    chk({tag, "_done_off"}, 32'(done), 32'd0);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
  endtask

  initial begin
    int lat;
    int seen;
    n_total = 0;
    n_bad   = 0;
    rst = 1'b1; start = 1'b0; sub = 1'b0; A = 8'h00; B = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_y", 32'(Y), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
`ifdef SERIAL_ADDSUB_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif

    run_op("add1", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0);
    run_op("addwrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("subbor", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op("addovf", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("subovf", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    run_op("subzero", 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);

    // Start during RUN with new operands is ignored; captured copies are used.
    A = 8'h3C; B = 8'h05; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_y_held", 32'(Y), 32'd0);
    tick();
    tick();
    A = 8'hFF; B = 8'hFF; sub = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_ready", 32'(ready), 32'd0);
    lat = 4;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    chk("ign_lat", 32'(lat), 32'd9);
    chk("ign_y", 32'(Y), 32'h41);
    chk("ign_carry", 32'(carry), 32'd0);
    tick();
    chk("ign_idle", 32'(ready), 32'd1);
    tick();
    chk("ign_notqueued", 32'(busy), 32'd0);

    // Start held across DONE->IDLE: accepted on the first IDLE edge.
    A = 8'h10; B = 8'h20; sub = 1'b0; start = 1'b1;
    tick();
    wait_done(lat);
    chk("hold_y1", 32'(Y), 32'h30);
    A = 8'h50; B = 8'h10; sub = 1'b1;
    tick();
    chk("hold_idle", 32'(ready), 32'd1);
    tick();
    start = 1'b0;
    chk("hold_busy", 32'(busy), 32'd1);
    wait_done(lat);
    chk("hold_lat", 32'(lat), 32'd9);
    chk("hold_y2", 32'(Y), 32'h40);
    chk("hold_carry2", 32'(carry), 32'd1);
    tick();

    // Reset mid-RUN aborts the op and clears the result.
    A = 8'h7F; B = 8'h01; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_y", 32'(Y), 32'd0);
    chk("abort_carry", 32'(carry), 32'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) seen++;
    end
    chk("abort_nodone", 32'(seen), 32'd0);

    run_op("post", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
